if_stage_ctrl: RTL and testbench
================================

// Module: if_stage_ctrl
// PURPOSE
//  Fetch stage and IF/ID pipeline register that act on the stall/flush controls from hazard_dect.
//  Holds the PC and fetches from instruction memory. Latches the fetched word into IF/ID.
//  Obeys hold_pc / hold_if (load-use stall) and if_flush (taken branch: redirect plus bubble).
//  Counts stall and flush cycles for performance monitoring.
// PARAMETERS
//  PC_WIDTH    32          width of PC and instruction-memory byte address
//  DATA_WIDTH  32          instruction word width
//  RESET_PC    32'h0       PC value loaded on reset
//  NOP_INSTR   32'h0       word inserted into IF/ID on flush or reset (bubble)
//  CNT_WIDTH   16          width of the performance counters
// PORTS
//  clk            in   1           single clock; all state updates on rising edge
//  rst            in   1           synchronous reset, active-high
//  hold_pc        in   1           freeze PC this cycle (from hazard_dect)
//  hold_if        in   1           freeze IF/ID register this cycle (from hazard_dect)
//  if_flush       in   1           taken branch: squash IF/ID, redirect PC (from hazard_dect)
//  branch_target  in   PC_WIDTH    redirect address, valid when if_flush=1
//  imem_addr      out  PC_WIDTH    instruction memory address (= PC register)
//  imem_rd_en     out  1           instruction memory read enable
//  imem_rdata     in   DATA_WIDTH  instruction word, combinational from imem_addr (same cycle)
//  pc_id          out  PC_WIDTH    PC of the instruction held in IF/ID
//  pc_plus4_id    out  PC_WIDTH    pc_id + 4, for the branch adder in ID
//  instr_id       out  DATA_WIDTH  instruction held in IF/ID
//  valid_id       out  1           IF/ID holds a real (non-bubble) instruction
//  stall_cnt      out  CNT_WIDTH   cycles with hold_pc=1 since reset
//  flush_cnt      out  CNT_WIDTH   cycles with if_flush=1 since reset
// BEHAVIOUR
//  Reset (rst=1 at an edge; overrides every other input):
//   - pc <= RESET_PC; instr_id <= NOP_INSTR; pc_id <= 0; pc_plus4_id <= 0; valid_id <= 0.
//   - stall_cnt <= 0; flush_cnt <= 0.
//   - Reset asserted mid-stall or mid-flush discards that event. First fetch after reset is RESET_PC.
//  imem_addr = pc (registered). imem_rd_en = !rst && !hold_pc (combinational).
//  PC update at each non-reset edge, in priority order:
//   1. if_flush=1 -> pc <= branch_target. Overrides hold_pc: branch is older than the stalled load-use.
//   2. hold_pc=1 -> pc unchanged.
//   3. else      -> pc <= pc + 4. Modulo 2^PC_WIDTH; 'hFFFFFFFC wraps to 0 with no flag.
//  IF/ID update at each non-reset edge, in priority order:
//   1. if_flush=1 -> instr_id <= NOP_INSTR; valid_id <= 0; pc_id/pc_plus4_id <= 0.
//   2. hold_if=1  -> all IF/ID fields unchanged.
//   3. else -> instr_id <= imem_rdata; pc_id <= pc; pc_plus4_id <= pc+4 (mod 2^PC_WIDTH); valid_id <= 1.
//  Latency: a word fetched at PC in cycle N appears on instr_id/pc_id after edge N+1.
//   Branch penalty is one bubble. First valid fetch from branch_target reaches IF/ID one cycle after the bubble.
//  hold_pc=1 with hold_if=0 is legal: IF/ID reloads the same PC, so a duplicate is fetched.
//   hold_if=1 with hold_pc=0 is legal: the word fetched that cycle is dropped.
//  Counters: increment by 1 per qualifying cycle. They saturate at all-ones and never wrap.
//   A cycle with hold_pc=1 and if_flush=1 increments both counters.
//  No X propagation: imem_rdata is sampled only when IF/ID loads (step 3).
// TESTING
//  T1 reset: hold rst 2 cycles, release -> imem_addr=0, valid_id=0, instr_id=NOP, both counters 0.
//   Next edge: pc_id=0, instr_id=mem[0], valid_id=1.
//  T2 sequential: mem[0..3]=A,B,C,D, no hazards -> instr_id shows A,B,C,D on consecutive cycles,
//   pc_id=0,4,8,12, pc_plus4_id=4,8,12,16.
//  T3 load-use stall: assert hold_pc=hold_if=1 for 1 cycle while pc_id=4 -> instr_id stays B 2 cycles,
//   C follows with no skip/dup, stall_cnt=1, imem_rd_en=0 during the stall.
//  T4 branch: if_flush=1, branch_target=0x40 while pc=8 -> next edge valid_id=0, instr_id=NOP, imem_addr=0x40.
//   Following edge pc_id=0x40, flush_cnt=1.
//  T5 simultaneous: hold_pc=hold_if=if_flush=1 -> PC takes branch_target, IF/ID bubbles,
//   stall_cnt and flush_cnt both +1.
//  T6 boundaries: RESET_PC='hFFFFFFFC -> second fetch at 0. Force stall_cnt to all-ones, stall again -> stays all-ones.
//   rst during stall -> imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/if_stage_ctrl_if.sv
// Fetch-stage bundle: hazard controls in, instruction-memory port, IF/ID outputs and perf counters.
interface if_stage_ctrl_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    // Hazard controls
    logic                  hold_pc;
    logic                  hold_if;
    logic                  if_flush;
    logic [PC_WIDTH-1:0]   branch_target;

    // Instruction memory port
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_rd_en;
    logic [DATA_WIDTH-1:0] imem_rdata;

    // IF/ID register contents
    logic [PC_WIDTH-1:0]   pc_id;
    logic [PC_WIDTH-1:0]   pc_plus4_id;
    logic [DATA_WIDTH-1:0] instr_id;
    logic                  valid_id;

    // Performance counters
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  flush_cnt;

    // Fetch stage side
    modport master (
        input  hold_pc, hold_if, if_flush, branch_target, imem_rdata,
        output imem_addr, imem_rd_en, pc_id, pc_plus4_id, instr_id, valid_id,
        stall_cnt, flush_cnt
    );

    // Environment side: hazard unit, instruction memory, decode stage
    modport slave (
        output hold_pc, hold_if, if_flush, branch_target, imem_rdata,
        input  imem_addr, imem_rd_en, pc_id, pc_plus4_id, instr_id, valid_id,
        stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// Fetch stage: PC register, instruction fetch and IF/ID register driven by stall/flush controls.
module if_stage_ctrl #(
    parameter int unsigned            PC_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = '0,
    parameter int unsigned            CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    if_stage_ctrl_if.master    bus
);

    localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [PC_WIDTH-1:0]   pc_plus4;

    logic [PC_WIDTH-1:0]   pc_id;
    logic [PC_WIDTH-1:0]   pc_plus4_id;
    logic [DATA_WIDTH-1:0] instr_id;
    logic                  valid_id;

    logic [PC_WIDTH-1:0]   pc_id_next;
    logic [PC_WIDTH-1:0]   pc_plus4_id_next;
    logic [DATA_WIDTH-1:0] instr_id_next;
    logic                  valid_id_next;

    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  flush_cnt;

    // Sequential fetch address; wraps modulo 2^PC_WIDTH without a flag
    assign pc_plus4 = pc + PC_STEP;

    // Next PC: a taken branch is older than the stalled load-use, so flush beats hold
    always_comb begin
        pc_next = pc_plus4;
        if (bus.if_flush) begin
            pc_next = bus.branch_target;
        end else if (bus.hold_pc) begin
            pc_next = pc;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID next value: bubble on flush, freeze on hold, otherwise capture this cycle's fetch
    always_comb begin
        pc_id_next       = pc_id;
        pc_plus4_id_next = pc_plus4_id;
        instr_id_next    = instr_id;
        valid_id_next    = valid_id;
        if (bus.if_flush) begin
            pc_id_next       = '0;
            pc_plus4_id_next = '0;
            instr_id_next    = NOP_INSTR;
            valid_id_next    = 1'b0;
        end else if (!bus.hold_if) begin
            pc_id_next       = pc;
            pc_plus4_id_next = pc_plus4;
            instr_id_next    = bus.imem_rdata;
            valid_id_next    = 1'b1;
        end
    end

    // IF/ID register; reset loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_id       <= '0;
            pc_plus4_id <= '0;
            instr_id    <= NOP_INSTR;
            valid_id    <= 1'b0;
        end else begin
            pc_id       <= pc_id_next;
            pc_plus4_id <= pc_plus4_id_next;
            instr_id    <= instr_id_next;
            valid_id    <= valid_id_next;
        end
    end

    // Saturating stall counter: one per cycle with hold_pc asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.hold_pc && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Saturating flush counter: one per cycle with if_flush asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (bus.if_flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    // Output mapping; the memory read enable follows the live stall/reset inputs
    assign bus.imem_addr   = pc;
    assign bus.imem_rd_en  = !rst && !bus.hold_pc;
    assign bus.pc_id       = pc_id;
    assign bus.pc_plus4_id = pc_plus4_id;
    assign bus.instr_id    = instr_id;
    assign bus.valid_id    = valid_id;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Scoreboard bench for if_stage_ctrl: a nominal instance and a wrap/saturation instance share stimulus.
module tb_if_stage_ctrl;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;
    localparam int          CMAX0 = 65535;
    localparam int          CMAX1 = 15;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        int          sc;
        int          fc;
        logic        rd_en;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hp  = 1'b0;
    logic        hi  = 1'b0;
    logic        fl  = 1'b0;
    logic [31:0] tgt = '0;

    int checks = 0;
    int errors = 0;

    st_t m0, m1;
    st_t q0[$];
    st_t q1[$];

    if_stage_ctrl_if #(.PC_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) b0 ();
    if_stage_ctrl_if #(.PC_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4))  b1 ();

    // Instruction memory contents as a pure function of the byte address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign b0.hold_pc = hp;  assign b1.hold_pc = hp;
    assign b0.hold_if = hi;  assign b1.hold_if = hi;
    assign b0.if_flush = fl; assign b1.if_flush = fl;
    assign b0.branch_target = tgt;
    assign b1.branch_target = tgt;
    assign b0.imem_rdata = memf(b0.imem_addr);
    assign b1.imem_rdata = memf(b1.imem_addr);

    if_stage_ctrl #(.PC_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC0),
                    .NOP_INSTR(32'h0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.master));

    if_stage_ctrl #(.PC_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC1),
                    .NOP_INSTR(32'h0), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.master));

    always #5 clk = ~clk;

    // Reference: architectural effect of one clock edge given the inputs held before it
    function automatic st_t step(input st_t s, input bit r, input bit h_pc, input bit h_if,
                                 input bit f, input logic [31:0] t,
                                 input logic [31:0] rpc, input int cmax);
        st_t n = s;
        n.rd_en = !r && !h_pc;
        if (r) begin
            n.pc = rpc; n.pc_id = 0; n.pc4 = 0; n.instr = 0; n.valid = 0;
            n.sc = 0;   n.fc = 0;
            return n;
        end
        if (f)          n.pc = t;
        else if (!h_pc) n.pc = s.pc + 32'd4;
        if (f) begin
            n.pc_id = 0; n.pc4 = 0; n.instr = 0; n.valid = 0;
        end else if (!h_if) begin
            n.pc_id = s.pc; n.pc4 = s.pc + 32'd4; n.instr = memf(s.pc); n.valid = 1;
        end
        if (h_pc && s.sc < cmax) n.sc = s.sc + 1;
        if (f && s.fc < cmax)    n.fc = s.fc + 1;
        return n;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input st_t e, input logic [31:0] addr,
                       input logic [31:0] pid, input logic [31:0] p4, input logic [31:0] ins,
                       input logic v, input logic rd, input logic [15:0] sc,
                       input logic [15:0] fc);
        chk("imem_addr", d, addr, e.pc);
        chk("pc_id", d, pid, e.pc_id);
        chk("pc_plus4_id", d, p4, e.pc4);
        chk("instr_id", d, ins, e.instr);
        chk("valid_id", d, 32'(v), 32'(e.valid));
        chk("imem_rd_en", d, 32'(rd), 32'(e.rd_en));
        chk("stall_cnt", d, 32'(sc), 32'(e.sc));
        chk("flush_cnt", d, 32'(fc), 32'(e.fc));
    endtask

    // Apply one cycle of inputs and queue the expected post-edge state of both instances
    task automatic drive(input bit r, input bit h_pc, input bit h_if, input bit f,
                         input logic [31:0] t);
        @(negedge clk);
        rst = r; hp = h_pc; hi = h_if; fl = f; tgt = t;
        m0 = step(m0, r, h_pc, h_if, f, t, RPC0, CMAX0);
        m1 = step(m1, r, h_pc, h_if, f, t, RPC1, CMAX1);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    // Monitor: compare after each rising edge against the oldest queued expectation
    initial begin
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, e, b0.imem_addr, b0.pc_id, b0.pc_plus4_id, b0.instr_id,
                    b0.valid_id, b0.imem_rd_en, b0.stall_cnt, b0.flush_cnt);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, e, b1.imem_addr, b1.pc_id, b1.pc_plus4_id, b1.instr_id,
                    b1.valid_id, b1.imem_rd_en, 16'(b1.stall_cnt), 16'(b1.flush_cnt));
            end
        end
    end

    // Stimulus: directed scenarios first, then constrained-random traffic
    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};

        repeat (2) drive(1, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h40);
        repeat (3) drive(0, 0, 0, 0, 0);

        drive(0, 1, 1, 1, 32'h80);
        repeat (2) drive(0, 0, 0, 0, 0);

        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 32'hFFFF_FFF8);
        repeat (3) drive(0, 0, 0, 0, 0);

        repeat (20) drive(0, 1, 1, 0, 0);
        repeat (18) drive(0, 0, 0, 1, 32'h100);
        drive(0, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h200);
        drive(1, 0, 0, 1, 32'h300);
        repeat (2) drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, a, b, f;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 85) ? a : ($urandom_range(0, 1) == 1);
            f = ($urandom_range(0, 99) < 15);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                            : ($urandom & 32'hFFFF_FFFC);
            drive(r, a, b, f, t);
        end

        drive(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
